// File: rtl/pipe_concat_stage.sv
// rtl/pipe_concat_stage.sv - registered 2W-bit packing stage with sequence tag and 2-entry skid buffer
module pipe_concat_stage #(
   parameter int W     = 32,
   parameter int SEQ_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_hi,
   input  logic [W-1:0]     in_lo,
   input  logic             in_swap,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   out_data,
   output logic [SEQ_W-1:0] out_seq,
   output logic [1:0]       occ
);

   // Main entry drives the outputs; skid entry catches one beat while the consumer stalls.
   logic             main_valid_q, main_valid_d;
   logic [2*W-1:0]   main_data_q,  main_data_d;
   logic [SEQ_W-1:0] main_seq_q,   main_seq_d;
   logic             skid_valid_q, skid_valid_d;
   logic [2*W-1:0]   skid_data_q,  skid_data_d;
   logic [SEQ_W-1:0] skid_seq_q,   skid_seq_d;
   logic [SEQ_W-1:0] seq_cnt_q,    seq_cnt_d;

   logic             accept;
   logic             fire;
   logic [2*W-1:0]   packed_beat;

   // Handshake terms; in_ready depends only on held state and flush, never on out_ready.
   always_comb begin
      in_ready    = ~skid_valid_q & ~flush;
      out_valid   = main_valid_q;
      out_data    = main_data_q;
      out_seq     = main_seq_q;
      occ         = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
      accept      = in_valid & in_ready;
      fire        = main_valid_q & out_ready;
      packed_beat = in_swap ? {in_lo, in_hi} : {in_hi, in_lo};
   end

   // Next-state selection in priority order: flush, skid refill, main load, skid load, drain.
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_seq_d   = main_seq_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_seq_d   = skid_seq_q;
      seq_cnt_d    = seq_cnt_q;

      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q && fire) begin
         main_data_d  = skid_data_q;
         main_seq_d   = skid_seq_q;
         skid_valid_d = 1'b0;
      end else if (accept && (!main_valid_q || out_ready)) begin
         main_valid_d = 1'b1;
         main_data_d  = packed_beat;
         main_seq_d   = seq_cnt_q;
         seq_cnt_d    = seq_cnt_q + SEQ_W'(1);
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = packed_beat;
         skid_seq_d   = seq_cnt_q;
         seq_cnt_d    = seq_cnt_q + SEQ_W'(1);
      end else if (fire) begin
         main_valid_d = 1'b0;
      end
   end

   // State register; reset discards every held beat and restarts the tag counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_seq_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_seq_q   <= '0;
         seq_cnt_q    <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_seq_q   <= main_seq_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_seq_q   <= skid_seq_d;
         seq_cnt_q    <= seq_cnt_d;
      end
   end

endmodule
